ddr_dimm_cmd_decoder: RTL

//  DIMM-side receiver for the DDR command bus driven by the controller PHY.

---
 rtl/ddr_dimm_cmd_decoder.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr_dimm_cmd_decoder.sv
// DDR command bus receiver for one DIMM rank.
// Decodes one command per clock from the control pins and tracks each bank's
// state and open row. It enforces tRCD/tRAS/tRP per bank and the REF/MRS
// global window. Accepted commands and violations are reported one cycle
// after the sampling edge. A rejected command leaves all state untouched.
module ddr_dimm_cmd_decoder #(
  parameter int CS_WIDTH   = 1,
  parameter int RANK_ID    = 0,
  parameter int BA_WIDTH   = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int T_RCD      = 4,
  parameter int T_RAS      = 12,
  parameter int T_RP       = 4,
  parameter int T_RFC      = 26,
  parameter int T_MRD      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cke_i,
  input  logic [CS_WIDTH-1:0]       cs_n_i,
  input  logic                      ras_n_i,
  input  logic                      cas_n_i,
  input  logic                      we_n_i,
  input  logic [BA_WIDTH-1:0]       ba_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  output logic                      cmd_valid_o,
  output logic [2:0]                cmd_o,
  output logic [BA_WIDTH-1:0]       cmd_ba_o,
  output logic [ADDR_WIDTH-1:0]     cmd_addr_o,
  output logic [ADDR_WIDTH-1:0]     cmd_row_o,
  output logic [(2**BA_WIDTH)-1:0]  bank_active_o,
  output logic                      busy_o,
  output logic                      err_o,
  output logic [2:0]                err_code_o
);

  localparam int NUM_BANKS = 2**BA_WIDTH;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;
  localparam logic [2:0] CMD_MRS  = 3'd7;

  // Counters are loaded with T-1 so that the command T cycles later sees 0.
  localparam logic [5:0] RCD_LD = 6'(T_RCD - 1);
  localparam logic [5:0] RAS_LD = 6'(T_RAS - 1);
  localparam logic [5:0] RP_LD  = 6'(T_RP - 1);
  localparam logic [5:0] RFC_LD = 6'(T_RFC - 1);
  localparam logic [5:0] MRD_LD = 6'(T_MRD - 1);

  typedef enum logic [1:0] {
    B_IDLE      = 2'd0,
    B_ACTIVE    = 2'd1,
    B_ACTIVE_AP = 2'd2,
    B_PRECHG    = 2'd3
  } bank_state_t;

  bank_state_t             st_q   [NUM_BANKS];
  bank_state_t             st_d   [NUM_BANKS];
  logic [5:0]              rcd_q  [NUM_BANKS];
  logic [5:0]              rcd_d  [NUM_BANKS];
  logic [5:0]              ras_q  [NUM_BANKS];
  logic [5:0]              ras_d  [NUM_BANKS];
  logic [5:0]              rp_q   [NUM_BANKS];
  logic [5:0]              rp_d   [NUM_BANKS];
  logic [ADDR_WIDTH-1:0]   row_q  [NUM_BANKS];
  logic [ADDR_WIDTH-1:0]   row_d  [NUM_BANKS];
  logic [5:0]              gbl_q, gbl_d;

  logic                    cmd_valid_q, cmd_valid_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [BA_WIDTH-1:0]     cmd_ba_q, cmd_ba_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [ADDR_WIDTH-1:0]   cmd_row_q, cmd_row_d;
  logic                    err_q, err_d;
  logic [2:0]              err_code_q, err_code_d;

  logic [2:0]              cmd_dec;
  logic [2:0]              viol_code;
  logic                    accept;
  logic                    any_open;
  logic                    prea_ras_err;
  bank_state_t             tgt_st;
  logic [5:0]              tgt_rcd, tgt_ras, tgt_rp;
  logic [ADDR_WIDTH-1:0]   tgt_row;

  function automatic logic [5:0] sat_dec(input logic [5:0] v);
    return (v != 6'd0) ? (v - 6'd1) : 6'd0;
  endfunction

  assign tgt_st  = st_q[ba_i];
  assign tgt_rcd = rcd_q[ba_i];
  assign tgt_ras = ras_q[ba_i];
  assign tgt_rp  = rp_q[ba_i];
  assign tgt_row = row_q[ba_i];

  // Decode the pin pattern into a command; unselected cycles are NOP.
  always_comb begin
    cmd_dec = CMD_NOP;
    if (cke_i && !cs_n_i[RANK_ID]) begin
      case ({ras_n_i, cas_n_i, we_n_i})
        3'b011:  cmd_dec = CMD_ACT;
        3'b101:  cmd_dec = CMD_RD;
        3'b100:  cmd_dec = CMD_WR;
        3'b010:  cmd_dec = addr_i[10] ? CMD_PREA : CMD_PRE;
        3'b001:  cmd_dec = CMD_REF;
        3'b000:  cmd_dec = CMD_MRS;
        default: cmd_dec = CMD_NOP;
      endcase
    end
  end

  // Summarise bank status for REF/MRS and PREA checks.
  // A PRECHG bank whose rp_cnt has expired counts as idle.
  always_comb begin
    any_open     = 1'b0;
    prea_ras_err = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!((st_q[b] == B_IDLE) || ((st_q[b] == B_PRECHG) && (rp_q[b] == 6'd0))))
        any_open = 1'b1;
      if ((st_q[b] == B_ACTIVE) && (ras_q[b] != 6'd0))
        prea_ras_err = 1'b1;
    end
  end

  // Classify the sampled command; the lowest violation code is reported.
  always_comb begin
    viol_code = 3'd0;
    if (cmd_dec != CMD_NOP) begin
      if (gbl_q != 6'd0) begin
        viol_code = 3'd1;
      end else begin
        case (cmd_dec)
          CMD_ACT: begin
            if ((tgt_st == B_ACTIVE) || (tgt_st == B_ACTIVE_AP))
              viol_code = 3'd2;
            else if ((tgt_st == B_PRECHG) && (tgt_rp != 6'd0))
              viol_code = 3'd3;
          end
          CMD_RD, CMD_WR: begin
            if (tgt_st != B_ACTIVE)
              viol_code = 3'd4;
            else if (tgt_rcd != 6'd0)
              viol_code = 3'd5;
          end
          CMD_PRE: begin
            if ((tgt_st == B_ACTIVE) && (tgt_ras != 6'd0))
              viol_code = 3'd6;
          end
          CMD_PREA: begin
            if (prea_ras_err)
              viol_code = 3'd6;
          end
          CMD_REF, CMD_MRS: begin
            if (any_open)
              viol_code = 3'd7;
          end
          default: viol_code = 3'd0;
        endcase
      end
    end
  end

  assign accept = (cmd_dec != CMD_NOP) && (viol_code == 3'd0);

  // Per-bank next state: free-running timers, auto transitions, then the accepted command.
  always_comb begin
    gbl_d = sat_dec(gbl_q);
    if (accept && (cmd_dec == CMD_REF)) gbl_d = RFC_LD;
    if (accept && (cmd_dec == CMD_MRS)) gbl_d = MRD_LD;
    for (int b = 0; b < NUM_BANKS; b++) begin
      st_d[b]  = st_q[b];
      row_d[b] = row_q[b];
      rcd_d[b] = sat_dec(rcd_q[b]);
      ras_d[b] = sat_dec(ras_q[b]);
      rp_d[b]  = sat_dec(rp_q[b]);
      case (st_q[b])
        B_ACTIVE_AP: begin
          if (ras_q[b] == 6'd0) begin
            st_d[b] = B_PRECHG;
            rp_d[b] = RP_LD;
          end
        end
        B_PRECHG: begin
          if (rp_q[b] == 6'd0) st_d[b] = B_IDLE;
        end
        default: ;
      endcase
      if (accept) begin
        if ((cmd_dec == CMD_PREA) && (st_q[b] == B_ACTIVE)) begin
          st_d[b] = B_PRECHG;
          rp_d[b] = RP_LD;
        end
        if (b == int'(ba_i)) begin
          case (cmd_dec)
            CMD_ACT: begin
              st_d[b]  = B_ACTIVE;
              row_d[b] = addr_i;
              rcd_d[b] = RCD_LD;
              ras_d[b] = RAS_LD;
            end
            CMD_RD, CMD_WR: begin
              if (addr_i[10]) st_d[b] = B_ACTIVE_AP;
            end
            CMD_PRE: begin
              if (st_q[b] == B_ACTIVE) begin
                st_d[b] = B_PRECHG;
                rp_d[b] = RP_LD;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Output report for the command sampled this edge; err_code holds until the next error.
  always_comb begin
    cmd_valid_d = accept;
    cmd_d       = accept ? cmd_dec : CMD_NOP;
    cmd_ba_d    = accept ? ba_i : '0;
    cmd_addr_d  = '0;
    cmd_row_d   = '0;
    if (accept) begin
      cmd_addr_d = addr_i;
      if ((cmd_dec == CMD_RD) || (cmd_dec == CMD_WR)) begin
        cmd_addr_d[10] = 1'b0;
        cmd_row_d      = tgt_row;
      end
    end
    err_d      = (viol_code != 3'd0);
    err_code_d = (viol_code != 3'd0) ? viol_code : err_code_q;
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        st_q[b]  <= B_IDLE;
        rcd_q[b] <= 6'd0;
        ras_q[b] <= 6'd0;
        rp_q[b]  <= 6'd0;
        row_q[b] <= '0;
      end
      gbl_q       <= 6'd0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      cmd_ba_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_row_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        st_q[b]  <= st_d[b];
        rcd_q[b] <= rcd_d[b];
        ras_q[b] <= ras_d[b];
        rp_q[b]  <= rp_d[b];
        row_q[b] <= row_d[b];
      end
      gbl_q       <= gbl_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_row_q   <= cmd_row_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Bank is reported active from ACT until it enters precharge (auto-precharge pending included).
  always_comb begin
    bank_active_o = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      bank_active_o[b] = (st_q[b] == B_ACTIVE) || (st_q[b] == B_ACTIVE_AP);
  end

  assign busy_o      = (gbl_q != 6'd0);
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_o       = cmd_q;
  assign cmd_ba_o    = cmd_ba_q;
  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_row_o   = cmd_row_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule
